multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/op_decoder.sv | 39 +++
 rtl/multicycle_sequencer.sv | 164 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, instruction opcodes,
// ALU0 operation codes, PC source selects and the decoded instruction classes.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_BNE = 4'd14;
    localparam logic [3:0] OP_J   = 4'd15;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_UADD = 3'd2;
    localparam logic [2:0] ALU_SADD = 3'd4;
    localparam logic [2:0] ALU_SSUB = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BNE = 3'd3,
        CLS_J   = 3'd4
    } op_class_e;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: legality, instruction class and the ALU0 code used in EXEC.
module op_decoder
    import proc_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       legal_o,
    output logic [2:0] cls_o,
    output logic [2:0] alu_op_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        legal_o  = 1'b1;
        cls_o    = CLS_ALU;
        alu_op_o = ALU_AND;
        case (opcode_i)
            OP_AND: alu_op_o = ALU_AND;
            OP_OR:  alu_op_o = ALU_OR;
            OP_ADD: alu_op_o = ALU_SADD;
            OP_SUB: alu_op_o = ALU_SSUB;
            OP_SLT: alu_op_o = ALU_SLT;
            OP_LW: begin
                cls_o    = CLS_LW;
                alu_op_o = ALU_UADD;
            end
            OP_SW: begin
                cls_o    = CLS_SW;
                alu_op_o = ALU_UADD;
            end
            OP_BNE: begin
                cls_o    = CLS_BNE;
                alu_op_o = ALU_SLT;
            end
            OP_J:    cls_o   = CLS_J;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with halt on illegal
// opcode or data-memory timeout, plus a wrapping count of retired instructions.
module multicycle_sequencer
    import proc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_load,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        m0_sel,
    output logic        m1_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] retired
);

    localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    logic [3:0]        dec_opcode;
    logic              dec_legal;
    logic [2:0]        dec_cls;
    logic [2:0]        dec_alu_op;

    // DECODE judges the live opcode; every later state works from the latched copy.
    assign dec_opcode = (state_q == ST_DECODE) ? opcode : op_q;

    op_decoder u_op_decoder (
        .opcode_i (dec_opcode),
        .legal_o  (dec_legal),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu_op)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = run ? ST_DECODE : ST_IDLE;
            ST_DECODE: begin
                op_d = opcode;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                case (dec_cls)
                    CLS_ALU:        state_d = ST_WB;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // A ready on the last allowed wait cycle still completes the access.
                if (mem_ready) begin
                    state_d = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_load  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_src    = PC_SEQ;
        alu_op    = ALU_AND;
        m0_sel    = 1'b0;
        m1_sel    = 1'b0;
        case (state_q)
            ST_FETCH: ir_write = run;
            ST_EXEC: begin
                alu_op = dec_alu_op;
                m0_sel = (dec_cls == CLS_LW) || (dec_cls == CLS_SW);
                if (dec_cls == CLS_BNE) begin
                    pc_write = 1'b1;
                    pc_src   = eq ? PC_SEQ : PC_BRANCH;
                end else if (dec_cls == CLS_J) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
            end
            ST_MEM: begin
                alu_op    = ALU_UADD;
                m0_sel    = 1'b1;
                mem_read  = (dec_cls == CLS_LW);
                mem_write = (dec_cls == CLS_SW);
                pc_write  = (dec_cls == CLS_SW) && mem_ready;
            end
            ST_WB: begin
                reg_load = 1'b1;
                pc_write = 1'b1;
                m1_sel   = (dec_cls != CLS_LW);
            end
            default: ;
        endcase
    end

    assign retired_d = retired_q + {15'd0, pc_write};

    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed vector table, hand-written
// corner sequences and randomized instructions scored against a latency-level model.
module tb_multicycle_sequencer;

    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        clear, run, eq, mem_ready;
    logic [3:0]  opcode;
    logic        ir_write, pc_write, reg_load, mem_read, mem_write;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic        m0_sel, m1_sel;
    logic [2:0]  state;
    logic        halted, illegal, timeout;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_retired = 0;

    multicycle_sequencer #(.MEM_WAIT_MAX(MAX)) dut (
        .clk       (clk),
        .clear     (clear),
        .run       (run),
        .opcode    (opcode),
        .eq        (eq),
        .mem_ready (mem_ready),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_load  (reg_load),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .m0_sel    (m0_sel),
        .m1_sel    (m1_sel),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal),
        .timeout   (timeout),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles;
        int n_ir;
        int n_pc;
        int n_reg;
        int n_rd;
        int n_wr;
        int alu_exec;
        int m0_exec;
        int pc_src;
        int m1;
        int bad;
    } obs_t;

    typedef struct {
        logic [3:0] op;
        logic       eqv;
        int         waits;
        int         cycles;
        int         alu;
        int         pc_src;
        int         mem_cyc;
        int         m1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] quiet_bits();
        return 32'({ir_write, pc_write, reg_load, mem_read, mem_write, pc_src, alu_op, m0_sel, m1_sel});
    endfunction

    // Expected behaviour of one instruction from its opcode, eq and number of
    // unready MEM cycles, using the latency/strobe rules directly.
    function automatic obs_t model(input int op, input bit eqv, input int waits,
                                   output bit ill, output bit tmo);
        obs_t e;
        int   alu_tab[16];
        alu_tab = '{0, 1, 4, 0, 0, 0, 5, 7, 2, 0, 2, 0, 0, 0, 7, 0};
        e   = '{default: 0};
        ill = 1'b0;
        tmo = 1'b0;
        e.n_ir = 1;
        if (!(op inside {0, 1, 2, 6, 7, 8, 10, 14, 15})) begin
            ill      = 1'b1;
            e.cycles = 2;
            return e;
        end
        e.alu_exec = alu_tab[op];
        e.m0_exec  = (op == 8 || op == 10) ? 1 : 0;
        if (op <= 7) begin
            e.cycles = 4; e.n_pc = 1; e.n_reg = 1; e.m1 = 1;
        end else if (op == 8 || op == 10) begin
            if (waits >= MAX) begin
                tmo      = 1'b1;
                e.cycles = 3 + MAX;
                if (op == 8) e.n_rd = MAX;
                else         e.n_wr = MAX;
            end else if (op == 8) begin
                e.cycles = 5 + waits; e.n_rd = waits + 1; e.n_pc = 1; e.n_reg = 1;
            end else begin
                e.cycles = 4 + waits; e.n_wr = waits + 1; e.n_pc = 1;
            end
        end else begin
            e.cycles = 3;
            e.n_pc   = 1;
            e.pc_src = (op == 15) ? 2 : (eqv ? 0 : 1);
        end
        return e;
    endfunction

    // Starts on a falling edge with the DUT in FETCH; runs until it is back in FETCH
    // or halts. Inputs the DUT must ignore in a given cycle are randomized.
    task automatic run_instr(input logic [3:0] op, input logic eqv, input int waits, output obs_t o);
        int cyc;
        cyc = 0;
        o   = '{default: 0};
        while (1) begin
            run       = (cyc == 0) ? 1'b1 : 1'($urandom);
            opcode    = (cyc == 1) ? op : 4'($urandom);
            eq        = (cyc == 2) ? eqv : 1'($urandom);
            mem_ready = (cyc >= 3 + waits);
            #1;
            if (ir_write)  o.n_ir++;
            if (pc_write)  o.n_pc++;
            if (reg_load)  o.n_reg++;
            if (mem_read)  o.n_rd++;
            if (mem_write) o.n_wr++;
            if (cyc == 2) begin
                o.alu_exec = int'(alu_op);
                o.m0_exec  = int'(m0_sel);
            end
            if (pc_write) o.pc_src = int'(pc_src);
            if (reg_load) o.m1 = int'(m1_sel);
            if ((mem_read && mem_write) ||
                (cyc == 1 && (ir_write || pc_write || reg_load || mem_read || mem_write)) ||
                (m1_sel && !reg_load) || (pc_src != 2'b00 && !pc_write))
                o.bad = 1;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (state == 3'd1 || state == 3'd6 || cyc >= 60) break;
        end
        o.cycles = cyc;
    endtask

    task automatic restart();
        clear = 1'b0;
        run   = 1'b0;
        #2;
        check("rst.state", 32'(state), 0);
        check("rst.retired", 32'(retired), 0);
        check("rst.status", 32'({halted, illegal, timeout}), 0);
        check("rst.strobes", quiet_bits(), 0);
        @(negedge clk);
        clear = 1'b1;
        run   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst.fetch", 32'(state), 1);
        exp_retired = 0;
    endtask

    task automatic check_model(input string tag, input int op, input bit eqv, input int waits,
                               input obs_t o);
        obs_t e;
        bit   ill, tmo;
        e = model(op, eqv, waits, ill, tmo);
        check({tag, ".cycles"},   o.cycles,   e.cycles);
        check({tag, ".ir_write"}, o.n_ir,     e.n_ir);
        check({tag, ".pc_write"}, o.n_pc,     e.n_pc);
        check({tag, ".reg_load"}, o.n_reg,    e.n_reg);
        check({tag, ".mem_read"}, o.n_rd,     e.n_rd);
        check({tag, ".mem_wr"},   o.n_wr,     e.n_wr);
        check({tag, ".alu_op"},   o.alu_exec, e.alu_exec);
        check({tag, ".m0_sel"},   o.m0_exec,  e.m0_exec);
        check({tag, ".pc_src"},   o.pc_src,   e.pc_src);
        check({tag, ".m1_sel"},   o.m1,       e.m1);
        check({tag, ".rules"},    o.bad,      0);
        exp_retired = (exp_retired + e.n_pc) % 65536;
        check({tag, ".retired"},  32'(retired), exp_retired);
        check({tag, ".halted"},   32'(halted),  32'(ill | tmo));
        check({tag, ".illegal"},  32'(illegal), 32'(ill));
        check({tag, ".timeout"},  32'(timeout), 32'(tmo));
        if (ill || tmo) check({tag, ".halt_quiet"}, quiet_bits(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        obs_t o;
        int   exp_states[5];
        int   bad_halt;
        int   legal_ops[9];
        int   illegal_ops[7];
        int   op, waits;
        bit   eqv;

        vecs = '{
            '{4'd2,  1'b0, 0, 4,  4, 0, 0, 1},
            '{4'd0,  1'b0, 0, 4,  0, 0, 0, 1},
            '{4'd1,  1'b1, 2, 4,  1, 0, 0, 1},
            '{4'd6,  1'b0, 0, 4,  5, 0, 0, 1},
            '{4'd7,  1'b0, 1, 4,  7, 0, 0, 1},
            '{4'd8,  1'b0, 3, 8,  2, 0, 4, 0},
            '{4'd8,  1'b1, 0, 5,  2, 0, 1, 0},
            '{4'd10, 1'b0, 0, 4,  2, 0, 1, 0},
            '{4'd10, 1'b0, 7, 11, 2, 0, 8, 0},
            '{4'd14, 1'b0, 0, 3,  7, 1, 0, 0},
            '{4'd14, 1'b1, 0, 3,  7, 0, 0, 0},
            '{4'd15, 1'b0, 0, 3,  0, 2, 0, 0}
        };
        legal_ops   = '{0, 1, 2, 6, 7, 8, 10, 14, 15};
        illegal_ops = '{3, 4, 5, 9, 11, 12, 13};

        clear = 1'b0; run = 1'b0; opcode = 4'd0; eq = 1'b0; mem_ready = 1'b0;
        #12;
        check("reset.state", 32'(state), 0);
        check("reset.retired", 32'(retired), 0);
        check("reset.status", 32'({halted, illegal, timeout}), 0);
        check("reset.strobes", quiet_bits(), 0);

        // ADD from reset: state walk and WB strobes.
        @(negedge clk);
        clear = 1'b1; run = 1'b1; opcode = 4'd2; mem_ready = 1'b0;
        #1;
        check("add.s0", 32'(state), 0);
        exp_states = '{1, 2, 3, 5, 1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("add.s%0d", i + 1), 32'(state), exp_states[i]);
            if (i == 2) check("add.alu_op", 32'(alu_op), 4);
            if (i == 3) check("add.wb", 32'({reg_load, pc_write}), 3);
        end
        check("add.retired", 32'(retired), 1);
        exp_retired = 1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].eqv, vecs[i].waits, o);
            check($sformatf("vec%0d.cycles", i), o.cycles, vecs[i].cycles);
            check($sformatf("vec%0d.alu_op", i), o.alu_exec, vecs[i].alu);
            check($sformatf("vec%0d.pc_src", i), o.pc_src, vecs[i].pc_src);
            check($sformatf("vec%0d.mem_cyc", i), o.n_rd + o.n_wr, vecs[i].mem_cyc);
            check($sformatf("vec%0d.m1_sel", i), o.m1, vecs[i].m1);
            check($sformatf("vec%0d.rules", i), o.bad, 0);
            exp_retired = (exp_retired + 1) % 65536;
            check($sformatf("vec%0d.retired", i), 32'(retired), exp_retired);
        end
        if (state != 3'd1) restart();

        // Illegal opcode halts and ignores run until clear.
        run_instr(4'd3, 1'b0, 0, o);
        check_model("illegal", 3, 1'b0, 0, o);
        bad_halt = 0;
        for (int i = 0; i < 6; i++) begin
            run    = i[0];
            opcode = 4'(i);
            @(posedge clk);
            @(negedge clk);
            #1;
            if (state != 3'd6 || halted !== 1'b1 || illegal !== 1'b1 || quiet_bits() != 0)
                bad_halt++;
        end
        check("illegal.absorb", bad_halt, 0);
        restart();

        // SW with mem_ready never arriving times out.
        run_instr(4'd10, 1'b0, 1000, o);
        check_model("timeout", 10, 1'b0, 1000, o);
        restart();

        // Clear during a MEM wait aborts the store and resumes from IDLE.
        run_instr(4'd15, 1'b0, 0, o);
        check_model("pre_abort", 15, 1'b0, 0, o);
        run = 1'b1; opcode = 4'd10; eq = 1'b0; mem_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("abort.in_mem", 32'({state, mem_write}), 32'({3'd4, 1'b1}));
        #2 clear = 1'b0;
        #1;
        check("abort.state", 32'(state), 0);
        check("abort.retired", 32'(retired), 0);
        check("abort.strobes", quiet_bits(), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort.hold", 32'(state), 0);
        clear = 1'b1; run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort.fetch", 32'(state), 1);
        exp_retired = 0;
        run_instr(4'd2, 1'b0, 0, o);
        check_model("resume", 2, 1'b0, 0, o);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) op = illegal_ops[$urandom_range(0, 6)];
            else                           op = legal_ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) waits = MAX + int'($urandom_range(0, 3));
            else                           waits = int'($urandom_range(0, MAX - 1));
            eqv = 1'($urandom);
            run_instr(4'(op), eqv, waits, o);
            check_model($sformatf("rnd%0d", i), op, eqv, waits, o);
            if (state != 3'd1) restart();
        end

        // Jump straight to the top of the count instead of retiring 65535 instructions.
        force dut.retired_q = 16'hFFFF;
        run = 1'b1; opcode = 4'd15; eq = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        #1;
        check("wrap.pre", 32'(retired), 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wrap.pc_write", 32'(pc_write), 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wrap.zero", 32'(retired), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
